// File: rtl/spi_frame_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_frame_engine_if
//  Description : Bundle of the conditioned SPI inputs, the memory access
//                port and the MISO pad signals of spi_frame_engine.
//                  cs_n, sclk_pos, sclk_neg, mosi : conditioned SPI inputs
//                  mem_addr, mem_wr_en, mem_wr_data,
//                  mem_rd_en, mem_rd_data         : memory access port
//                  miso, miso_oe                  : MISO pad
//                  busy                           : frame in progress
//                slave  = frame engine side, master = environment side.
//  Revision    : 1.0  initial release
// ============================================================================
interface spi_frame_engine_if #(
    parameter int ADDRW = 7,
    parameter int DATAW = 8
);
    logic             cs_n;
    logic             sclk_pos;
    logic             sclk_neg;
    logic             mosi;
    logic [ADDRW-1:0] mem_addr;
    logic             mem_wr_en;
    logic [DATAW-1:0] mem_wr_data;
    logic             mem_rd_en;
    logic [DATAW-1:0] mem_rd_data;
    logic             miso;
    logic             miso_oe;
    logic             busy;

    modport slave (
        input  cs_n, sclk_pos, sclk_neg, mosi, mem_rd_data,
        output mem_addr, mem_wr_en, mem_wr_data, mem_rd_en, miso, miso_oe, busy
    );

    modport master (
        output cs_n, sclk_pos, sclk_neg, mosi, mem_rd_data,
        input  mem_addr, mem_wr_en, mem_wr_data, mem_rd_en, miso, miso_oe, busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_frame_engine.sv
`default_nettype none
// ============================================================================
//  Module      : spi_frame_engine
//  Description : Decodes SPI mode-0 frames (ADDRW address bits, one R/W bit
//                with 1 = read, then DATAW data bits, MSB first) into memory
//                accesses. Writes issue a single mem_wr_en strobe; reads
//                issue mem_rd_en, capture the byte one clock later and shift
//                it out on MISO at SCLK falling edges.
//  Ports       : clk   - system clock, rising edge
//                reset - asynchronous, active-high
//                bus   - spi_frame_engine_if.slave (SPI inputs, memory port,
//                        MISO pad, busy)
//  Revision    : 1.0  initial release
// ============================================================================
module spi_frame_engine #(
    parameter int ADDRW = 7,
    parameter int DATAW = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    spi_frame_engine_if.slave     bus
);

    // Shift register must hold the address plus R/W bit as well as a data byte.
    localparam int SW = (ADDRW + 1 > DATAW) ? (ADDRW + 1) : DATAW;
    localparam int CW = $clog2(ADDRW + DATAW + 1);

    // Counter value seen on the edge that carries the R/W bit / last data bit.
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDRW);
    localparam logic [CW-1:0] DATA_LAST = CW'(ADDRW + DATAW);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        RDREQ  = 3'd2,
        RDLOAD = 3'd3,
        READ   = 3'd4,
        WRITE  = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t           state;
    logic [SW-1:0]    shreg;
    logic [CW-1:0]    cnt;
    logic [ADDRW-1:0] addr_q;
    logic [DATAW-1:0] wr_data_q;
    logic             wr_en_q;
    logic             rd_en_q;
    logic             miso_q;
    logic             miso_oe_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
        end else begin
            // Strobes are single-cycle; they are re-armed only by a transition.
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;

            if (bus.cs_n) begin
                // Deselect wins over any same-cycle SCLK pulse.
                state     <= IDLE;
                cnt       <= '0;
                miso_q    <= 1'b0;
                miso_oe_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ADDR;
                        cnt   <= '0;
                    end

                    ADDR: begin
                        if (bus.sclk_pos) begin
                            shreg <= {shreg[SW-2:0], bus.mosi};
                            cnt   <= cnt + CW'(1);
                            if (cnt == ADDR_LAST) begin
                                // mosi carries R/W; the address is already in shreg.
                                addr_q <= shreg[ADDRW-1:0];
                                if (bus.mosi) begin
                                    state   <= RDREQ;
                                    rd_en_q <= 1'b1;
                                end else begin
                                    state   <= WRITE;
                                end
                            end
                        end
                    end

                    RDREQ: begin
                        state <= RDLOAD;
                    end

                    RDLOAD: begin
                        shreg     <= SW'(bus.mem_rd_data);
                        miso_oe_q <= 1'b1;
                        state     <= READ;
                    end

                    READ: begin
                        // A coincident rising pulse takes precedence, and READ
                        // has nothing to do on a rising pulse.
                        if (bus.sclk_neg && !bus.sclk_pos) begin
                            miso_q <= shreg[DATAW-1];
                            shreg  <= shreg << 1;
                            if (cnt == DATA_LAST) begin
                                state <= DONE;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end

                    WRITE: begin
                        if (bus.sclk_pos) begin
                            shreg <= {shreg[SW-2:0], bus.mosi};
                            if (cnt == DATA_LAST) begin
                                wr_data_q <= {shreg[DATAW-2:0], bus.mosi};
                                wr_en_q   <= 1'b1;
                                state     <= DONE;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end

                    DONE: begin
                        state <= DONE;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_wr_data = wr_data_q;
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.miso        = miso_q;
    assign bus.miso_oe     = miso_oe_q;
    assign bus.busy        = (state != IDLE);

endmodule
`default_nettype wire
